perf_count_ctrl: RTL and testbench
==================================

Name: perf_count_ctrl

Overview:
- Profiling controller for the multicycle processor's cycle counter.
- Sequences one measurement run through arm, start, count, halt and readout.
- Counts cycles, retired instructions and stall cycles between program start and halt.
- Serialises the three results to the display/host logic over a valid/ready handshake.

Parameters:
CNT_W, 16, width of each counter and of rd_data

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state and counters
arm  input  1  pulse; prepares a new run
start  input  1  level; processor has begun executing
halt  input  1  level; processor has stopped (stop instruction reached)
instr_retire  input  1  one-cycle pulse per completed instruction
stall  input  1  high during processor stall cycles
rd_ready  input  1  consumer accepts rd_data
rd_valid  output  1  rd_data/rd_idx valid
rd_idx  output  2  0=cycles, 1=instructions, 2=stalls
rd_data  output  CNT_W  selected counter value
busy  output  1  high in ARMED, COUNTING, STOPPED, READOUT
done  output  1  run complete, results available
overflow  output  1  sticky; any counter exceeded 2^CNT_W-1 in this run

Behaviour:
- Reset: reset, synchronous, active-high; clock clock.
  - State IDLE; cyc_cnt, ins_cnt, stl_cnt = 0.
  - rd_valid=0, rd_idx=0, rd_data=0, busy=0, done=0, overflow=0.
  - Reset asserted in any state, including mid-count or mid-readout, aborts the run to these values on the next edge.
- States: IDLE, ARMED, COUNTING, STOPPED, READOUT. Transitions are evaluated on the rising edge using current-state values.
- IDLE:
  - arm=1: clear all counters, clear done and overflow, go to ARMED.
  - Other inputs ignored.
- ARMED:
  - start=1: go to COUNTING. No increment occurs on this edge.
  - halt is ignored in ARMED.
  - Repeated arm has no effect.
- COUNTING: every edge spent in this state, including the edge that samples halt=1:
  - cyc_cnt += 1.
  - ins_cnt += 1 if instr_retire=1.
  - stl_cnt += 1 if stall=1.
  - halt=1: increments still apply on that edge, then go to STOPPED.
  - arm is ignored.
- STOPPED:
  - One cycle. Counters frozen. done set to 1.
  - Next edge goes to READOUT with rd_idx=0.
- READOUT:
  - rd_valid=1. rd_data is cyc_cnt, ins_cnt or stl_cnt per rd_idx.
  - On rd_valid&rd_ready, rd_idx advances on the next edge.
  - Acceptance at rd_idx=2: go to IDLE, rd_valid=0, rd_idx=0.
  - rd_data and rd_idx are held stable while rd_ready=0.
  - The handshake has no timeout.
- After readout: done stays 1 in IDLE until the next arm or reset. Counters hold their values until the next arm.
- Outside READOUT: rd_valid=0 and rd_data=0.
- Wrap-around without the optional feature:
  - Counters are modulo 2^CNT_W.
  - An increment from all-ones wraps to 0 and sets overflow.
  - overflow stays set until arm or reset.
- Simultaneous events:
  - instr_retire and stall in the same cycle increment both counters.
  - start and halt high on the same ARMED edge: go to COUNTING only; halt is acted on at the next COUNTING edge.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- Defined: each counter saturates at 2^CNT_W-1 and never wraps. An increment attempted at all-ones sets overflow and leaves the value unchanged.
- Undefined: counters wrap modulo 2^CNT_W, with overflow set as described in Behaviour.

Test Plan:
- Basic run:
  - Stimulus: reset, arm, start=1 on edge E0; instr_retire pulsed on 4 COUNTING cycles, stall high on 3; halt sampled on E10; rd_ready=1.
  - Response: readout idx0=10, idx1=4, idx2=3 on consecutive cycles; done=1; busy=0 after idx2.
- Back-pressure:
  - Stimulus: same run with rd_ready=0 for 5 cycles at idx1.
  - Response: rd_valid=1, rd_idx=1, rd_data=4 held stable all 5 cycles; advances to idx2 one edge after rd_ready=1.
- Reset mid-count:
  - Stimulus: reset asserted 6 cycles into COUNTING.
  - Response: next cycle state IDLE, all counters 0, busy=0, done=0; later start/halt without arm produce no counting.
- Ignored inputs:
  - Stimulus: arm pulsed during COUNTING; halt=1 while ARMED; start and halt both 1 on the ARMED edge.
  - Response: count is not cleared; no transition from halt in ARMED; in the start+halt case, cyc_cnt=1 at readout.
- Overflow, CNT_W=4, 20 counting cycles:
  - Without PERF_SATURATE_EN: idx0=4, overflow=1.
  - With PERF_SATURATE_EN: idx0=15, overflow=1.
  - Next arm clears overflow to 0.

Source files
------------

// File: rtl/perf_count_ctrl.sv
// Profiling controller: arms, counts cycles/instructions/stalls between start and halt, then reads results out.
// Optional macro PERF_SATURATE_EN makes counters saturate at all-ones instead of wrapping.
module perf_count_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arm,
  input  logic             start,
  input  logic             halt,
  input  logic             instr_retire,
  input  logic             stall,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [1:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [2:0] {IDLE, ARMED, COUNTING, STOPPED, READOUT} state_t;

  localparam logic [CNT_W-1:0] ONE_N = 1;
  localparam logic [CNT_W:0]   ONE_W = 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cyc_cnt, ins_cnt, stl_cnt;
  logic [CNT_W:0]   cyc_inc, ins_inc, stl_inc;

  // Top bit of the result flags an increment attempted at all-ones.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
    bump = (&v) ? {1'b1, v} : {1'b0, v + ONE_N};
`else
    bump = {1'b0, v} + ONE_W;
`endif
  endfunction

  assign cyc_inc = bump(cyc_cnt);
  assign ins_inc = bump(ins_cnt);
  assign stl_inc = bump(stl_cnt);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (arm)   state_next = ARMED;
      ARMED:    if (start) state_next = COUNTING;
      COUNTING: if (halt)  state_next = STOPPED;
      STOPPED:             state_next = READOUT;
      READOUT:  if (rd_ready && rd_idx == 2'd2) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt  <= '0;
      ins_cnt  <= '0;
      stl_cnt  <= '0;
      rd_idx   <= 2'd0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            cyc_cnt  <= '0;
            ins_cnt  <= '0;
            stl_cnt  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        COUNTING: begin
          cyc_cnt <= cyc_inc[CNT_W-1:0];
          if (instr_retire) ins_cnt <= ins_inc[CNT_W-1:0];
          if (stall)        stl_cnt <= stl_inc[CNT_W-1:0];
          if (cyc_inc[CNT_W] || (instr_retire && ins_inc[CNT_W]) || (stall && stl_inc[CNT_W]))
            overflow <= 1'b1;
          if (halt) done <= 1'b1;
        end
        STOPPED: rd_idx <= 2'd0;
        READOUT: begin
          if (rd_ready) rd_idx <= (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign rd_valid = (state == READOUT);
  assign busy     = (state != IDLE);

  always_comb begin
    rd_data = '0;
    if (state == READOUT) begin
      case (rd_idx)
        2'd0:    rd_data = cyc_cnt;
        2'd1:    rd_data = ins_cnt;
        default: rd_data = stl_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_count_ctrl.sv
// Self-checking bench for perf_count_ctrl: directed and randomized runs compared against a count-based model.
// Honours PERF_SATURATE_EN the same way as the design when it is defined for both.
module tb_perf_count_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset, arm, start, halt, instr_retire, stall, rd_ready;
  logic         rd_valid, busy, done, overflow;
  logic [1:0]   rd_idx;
  logic [W-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  perf_count_ctrl #(.CNT_W(W)) dut (
    .clock(clock), .reset(reset), .arm(arm), .start(start), .halt(halt),
    .instr_retire(instr_retire), .stall(stall), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected register value after n increments from zero.
  function automatic int expVal(input int n);
`ifdef PERF_SATURATE_EN
    return (n > MAXV) ? MAXV : n;
`else
    return n % (MAXV + 1);
`endif
  endfunction

  // One complete arm/start/count/halt/readout run; bpIdx=3 means no back-pressure.
  task automatic applyStimulus(input int n, input bit startHalt, input bit armMid, input bit haltInArmed,
                               input int bpIdx, input int bpLen, input bit rnd,
                               input logic [63:0] insMask, input logic [63:0] stlMask);
    int nIns = 0;
    int nStl = 0;
    int exp[3];
    bit expOvf;
    arm = 1'b1;
    step();
    arm = 1'b0;
    checkOutput("armed_busy", busy, 1);
    checkOutput("armed_ovf", overflow, 0);
    checkOutput("armed_done", done, 0);
    if (haltInArmed) begin
      halt = 1'b1;
      repeat (2) step();
      halt = 1'b0;
      checkOutput("armed_halt_busy", busy, 1);
      checkOutput("armed_halt_valid", rd_valid, 0);
    end
    start = 1'b1;
    halt  = startHalt;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      instr_retire = rnd ? 1'($urandom_range(0, 1)) : insMask[i];
      stall        = rnd ? 1'($urandom_range(0, 1)) : stlMask[i];
      halt         = (i == n - 1);
      arm          = armMid && (i == n / 2);
      nIns += int'(instr_retire);
      nStl += int'(stall);
      step();
    end
    instr_retire = 1'b0;
    stall = 1'b0;
    halt  = 1'b0;
    arm   = 1'b0;
    checkOutput("stopped_valid", rd_valid, 0);
    checkOutput("stopped_busy", busy, 1);
    step();
    exp[0] = expVal(n);
    exp[1] = expVal(nIns);
    exp[2] = expVal(nStl);
    expOvf = (n > MAXV);
    checkOutput("readout_done", done, 1);
    checkOutput("readout_ovf", overflow, 32'(expOvf));
    for (int idx = 0; idx < 3; idx++) begin
      checkOutput("rd_valid", rd_valid, 1);
      checkOutput("rd_idx", rd_idx, idx);
      checkOutput("rd_data", rd_data, exp[idx]);
      if (idx == bpIdx) begin
        rd_ready = 1'b0;
        repeat (bpLen) begin
          step();
          checkOutput("hold_valid", rd_valid, 1);
          checkOutput("hold_idx", rd_idx, idx);
          checkOutput("hold_data", rd_data, exp[idx]);
        end
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    checkOutput("end_valid", rd_valid, 0);
    checkOutput("end_busy", busy, 0);
    checkOutput("end_done", done, 1);
    checkOutput("end_idx", rd_idx, 0);
    checkOutput("end_data", rd_data, 0);
    checkOutput("end_ovf", overflow, 32'(expOvf));
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; start = 1'b0; halt = 1'b0;
    instr_retire = 1'b0; stall = 1'b0; rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_idx", rd_idx, 0);
    checkOutput("rst_data", rd_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", overflow, 0);

    // Basic run: 10 cycles, 4 retires, 3 stalls (two overlapping a retire).
    applyStimulus(10, 0, 0, 0, 3, 0, 0, 64'h00F0, 64'h0038);
    // Same run with five cycles of back-pressure on the instruction count.
    applyStimulus(10, 0, 0, 0, 1, 5, 0, 64'h00F0, 64'h0038);
    // Arm during counting and halt while armed are both ignored.
    applyStimulus(12, 0, 1, 1, 3, 0, 1, 64'h0, 64'h0);
    // start and halt together: exactly one counting edge.
    applyStimulus(1, 1, 0, 0, 3, 0, 0, 64'h1, 64'h0);
    // Twenty counting cycles overflow a 4-bit counter.
    applyStimulus(20, 0, 0, 0, 2, 2, 0, 64'hFFFFF, 64'h0);
    // Next arm must clear the sticky overflow (checked at arm inside the task).
    applyStimulus(3, 0, 0, 0, 3, 0, 0, 64'h0, 64'h7);

    // Reset six cycles into counting aborts the run.
    arm = 1'b1;
    step();
    arm = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) begin
      instr_retire = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b1;
    instr_retire = 1'b0;
    stall = 1'b0;
    step();
    reset = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ovf", overflow, 0);
    checkOutput("abort_valid", rd_valid, 0);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      halt = i[0];
      step();
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_valid", rd_valid, 0);
    end
    start = 1'b0;
    halt = 1'b0;

    for (int r = 0; r < 8; r++) begin
      applyStimulus(int'($urandom_range(1, 40)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1, 64'h0, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
